// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage. Holds the PC, drives the instruction SRAM
// read port, and hands {valid, pc} plus the returned instruction word to ID.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   stall[5:0]        - pipeline hold vector (bit0 = IF hold, bit1 = ID hold)
//   br_bus[32:0]      - {br_e, br_addr} branch redirect from ID
//   inst_sram_*       - SRAM port (read only; wen/wdata tied to zero)
//   if_to_id_bus      - {ce, pc} for the instruction being fetched
//   id_inst           - instruction word presented to ID
// Optional feature: define IF_INST_HOLD_BUF_EN to build the ID instruction hold
// buffer. It captures the SRAM data while ID is held, so the word survives the
// SRAM output changing underneath a stall.

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] id_inst
);

  // Reset parks the PC one word before the boot vector, so the first
  // un-stalled increment lands exactly on RESET_PC.
  localparam logic [31:0] RESET_FETCH = RESET_PC - 32'd4;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [31:0] next_pc;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // A live branch wins over a branch remembered from a stall; the sum wraps
  // at 32 bits.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (pend_vld) begin
      next_pc = pend_addr;
    end
  end

  // PC, fetch-enable and the pending-redirect latch. A branch that arrives
  // while IF is held would otherwise be lost, since ID only presents it for
  // one cycle; it is parked here and consumed on the first free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_FETCH;
      ce_reg    <= 1'b0;
      pend_vld  <= 1'b0;
      pend_addr <= 32'h0;
    end else if (!stall[0]) begin
      pc_reg   <= next_pc;
      ce_reg   <= 1'b1;
      pend_vld <= 1'b0;
    end else if (br_e) begin
      pend_vld  <= 1'b1;
      pend_addr <= br_addr;
    end
  end

  // The SRAM address comes straight from the register, so there is no
  // combinational path from br_bus to the SRAM port.
  assign inst_sram_en    = ce_reg;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign if_to_id_bus    = {ce_reg, pc_reg};

`ifdef IF_INST_HOLD_BUF_EN
  logic        hold_vld;
  logic [31:0] hold_reg;

  // Capture only on the first held edge: later edges of the same stall must
  // not overwrite the word ID is waiting on.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_reg <= 32'h0;
    end else if (stall[1]) begin
      if (!hold_vld) begin
        hold_vld <= 1'b1;
        hold_reg <= inst_sram_rdata;
      end
    end else begin
      hold_vld <= 1'b0;
    end
  end

  assign id_inst = hold_vld ? hold_reg : inst_sram_rdata;

  // Stall bits owned by later pipeline stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:2];
`else
  assign id_inst = inst_sram_rdata;

  // Stall bits owned by later pipeline stages (ID hold is only needed when
  // the hold buffer is built).
  logic unused_stall;
  assign unused_stall = ^stall[5:1];
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized plus directed bench for if_fetch. The stimulus
// process advances a reference model and queues the expected outputs for each
// cycle; a monitor on the falling edge pops and compares them.
// Ports exercised: all if_fetch ports. Honours IF_INST_HOLD_BUF_EN if defined.

module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] id_inst;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_bus         (br_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .if_to_id_bus   (if_to_id_bus),
    .id_inst        (id_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [32:0] bus;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: architectural PC, fetch-valid, at most one remembered
  // redirect (a queue of depth <= 1), and the ID hold buffer.
  logic [31:0] m_pc   = 32'h0;
  logic        m_ce   = 1'b0;
  logic [31:0] m_pend[$];
  logic        m_hvld = 1'b0;
  logic [31:0] m_hold = 32'h0;

  // Inputs currently on the DUT pins, i.e. what the next edge samples.
  logic        cur_rst;
  logic [5:0]  cur_stall;
  logic [32:0] cur_br;
  logic [31:0] cur_rd;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait for an edge, advance the model by what that edge sampled, apply new
  // inputs, and queue the outputs the DUT must show for the coming cycle.
  task automatic drive(input logic r, input logic [5:0] s, input logic be,
                       input logic [31:0] ba, input logic force_rd,
                       input logic [31:0] rd);
    logic [31:0] prev_pc;
    logic        prev_ce;
    logic [31:0] nrd;
    exp_t        e;
    @(posedge clk);
    #1;
    prev_pc = m_pc;
    prev_ce = m_ce;
    if (cur_rst) begin
      m_pc = RESET_PC - 32'd4;
      m_ce = 1'b0;
      m_pend.delete();
      m_hvld = 1'b0;
      m_hold = 32'h0;
    end else begin
      if (!cur_stall[0]) begin
        if (cur_br[32])            m_pc = cur_br[31:0];
        else if (m_pend.size() > 0) m_pc = m_pend[0];
        else                       m_pc = m_pc + 32'd4;
        m_ce = 1'b1;
        m_pend.delete();
      end else if (cur_br[32]) begin
        m_pend.delete();
        m_pend.push_back(cur_br[31:0]);
      end
`ifdef IF_INST_HOLD_BUF_EN
      if (cur_stall[1] && !m_hvld) begin
        m_hvld = 1'b1;
        m_hold = cur_rd;
      end else if (!cur_stall[1]) begin
        m_hvld = 1'b0;
      end
`endif
    end
    // The bench plays the SRAM: data for the previous cycle's address.
    if (force_rd)              nrd = rd;
    else if (prev_ce === 1'b1) nrd = memf(prev_pc);
    else                       nrd = $urandom();
    rst = r; stall = s; br_bus = {be, ba}; inst_sram_rdata = nrd;
    cur_rst = r; cur_stall = s; cur_br = {be, ba}; cur_rd = nrd;
    e.en   = m_ce;
    e.addr = m_pc;
    e.bus  = {m_ce, m_pc};
    e.inst = m_hvld ? m_hold : nrd;
    sb.push_back(e);
  endtask

  // One directed cycle with an explicit address/enable expectation.
  task automatic ds(input logic r, input logic [5:0] s, input logic be,
                    input logic [31:0] ba, input logic [31:0] ea,
                    input logic een, input string nm);
    drive(r, s, be, ba, 1'b0, 32'h0);
    #1;
    chk({nm, "_addr"}, 64'(inst_sram_addr), 64'(ea));
    chk({nm, "_en"}, 64'(inst_sram_en), 64'(een));
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare to the queue.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_en",    64'(inst_sram_en),    64'(e.en));
      chk("sb_addr",  64'(inst_sram_addr),  64'(e.addr));
      chk("sb_bus",   64'(if_to_id_bus),    64'(e.bus));
      chk("sb_inst",  64'(id_inst),         64'(e.inst));
      chk("sb_wen",   64'(inst_sram_wen),   64'(0));
      chk("sb_wdata", 64'(inst_sram_wdata), 64'(0));
    end
  end

  initial begin
    rst = 1'b1; stall = 6'h0; br_bus = 33'h0; inst_sram_rdata = 32'h0;
    cur_rst = 1'b1; cur_stall = 6'h0; cur_br = 33'h0; cur_rd = 32'h0;

    // Reset, release, free-running fetch.
    ds(1, 6'h0, 0, 0, 32'hBFBF_FFFC, 0, "rst0");
    ds(1, 6'h0, 0, 0, 32'hBFBF_FFFC, 0, "rst1");
    ds(0, 6'h0, 0, 0, 32'hBFBF_FFFC, 0, "rst_hold");
    ds(0, 6'h0, 0, 0, 32'hBFC0_0000, 1, "boot0");
    ds(0, 6'h0, 0, 0, 32'hBFC0_0004, 1, "boot4");
    ds(0, 6'h0, 0, 0, 32'hBFC0_0008, 1, "boot8");
    ds(0, 6'h0, 0, 0, 32'hBFC0_000C, 1, "bootC");

    // One-cycle branch at pc 0010.
    ds(0, 6'h0, 1, 32'hBFC0_0100, 32'hBFC0_0010, 1, "br_src");
    ds(0, 6'h0, 0, 0,             32'hBFC0_0100, 1, "br_tgt");
    ds(0, 6'h0, 0, 0,             32'hBFC0_0104, 1, "br_tgt4");

    // Branch arriving during a 3-cycle IF stall is remembered.
    ds(0, 6'h0, 1, 32'hBFC0_0020, 32'hBFC0_0108, 1, "st_pre");
    ds(0, 6'h1, 0, 0,             32'hBFC0_0020, 1, "st_at");
    ds(0, 6'h1, 1, 32'hBFC0_0200, 32'hBFC0_0020, 1, "st_h1");
    ds(0, 6'h1, 0, 0,             32'hBFC0_0020, 1, "st_h2");
    ds(0, 6'h0, 0, 0,             32'hBFC0_0020, 1, "st_h3");
    ds(0, 6'h0, 0, 0,             32'hBFC0_0200, 1, "st_pend");
    ds(0, 6'h0, 0, 0,             32'hBFC0_0204, 1, "st_clr");

    // 32-bit wrap.
    ds(0, 6'h0, 1, 32'hFFFF_FFF8, 32'hBFC0_0208, 1, "wr_pre");
    ds(0, 6'h0, 0, 0,             32'hFFFF_FFF8, 1, "wr_f8");
    ds(0, 6'h0, 0, 0,             32'hFFFF_FFFC, 1, "wr_fc");
    ds(0, 6'h0, 0, 0,             32'h0000_0000, 1, "wr_0");

    // Reset during a stall with a redirect pending.
    ds(0, 6'h1, 0, 0,             32'h0000_0004, 1, "rp_pre");
    ds(0, 6'h1, 1, 32'hBFC0_0300, 32'h0000_0004, 1, "rp_h1");
    ds(1, 6'h1, 0, 0,             32'h0000_0004, 1, "rp_h2");
    ds(0, 6'h0, 0, 0,             32'hBFBF_FFFC, 0, "rp_rst");
    ds(0, 6'h0, 0, 0,             32'hBFC0_0000, 1, "rp_boot");

`ifdef IF_INST_HOLD_BUF_EN
    // ID hold buffer keeps the word across a 2-cycle ID stall.
    drive(0, 6'h2, 0, 0, 1'b1, 32'h2402_0005);
    #1 chk("hb_rise", 64'(id_inst), 64'(32'h2402_0005));
    drive(0, 6'h2, 0, 0, 1'b1, 32'h0000_0000);
    #1 chk("hb_h1", 64'(id_inst), 64'(32'h2402_0005));
    drive(0, 6'h0, 0, 0, 1'b1, 32'h0000_0000);
    #1 chk("hb_h2", 64'(id_inst), 64'(32'h2402_0005));
    drive(0, 6'h0, 0, 0, 1'b1, 32'h0000_0011);
    #1 chk("hb_rel", 64'(id_inst), 64'(32'h0000_0011));
`else
    drive(0, 6'h2, 0, 0, 1'b1, 32'h2402_0005);
    #1 chk("id_pass", 64'(id_inst), 64'(32'h2402_0005));
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [5:0] s;
      logic       be;
      r     = ($urandom_range(0, 63) == 0);
      s     = 6'($urandom());
      s[0]  = ($urandom_range(0, 9) < 3);
      s[1]  = ($urandom_range(0, 9) < 3);
      be    = ($urandom_range(0, 99) < 15);
      drive(r, s, be, $urandom() & 32'hFFFF_FFFC, 1'b0, 32'h0);
    end

    drive(0, 6'h0, 0, 0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
